// File: rtl/trng_ctrl.sv
// Sequencing controller for the TRNG core: warm-up gating, word packing with
// valid/ready delivery, and continuous repetition/starvation health tests.
module trng_ctrl #(
  parameter int WORD_W        = 32,
  parameter int WARMUP_CYCLES = 256,
  parameter int REP_LIMIT     = 32,
  parameter int TIMEOUT       = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear_fail,
  input  logic              rnd_bit,
  input  logic              rnd_valid,
  input  logic              word_ready,
  output logic              trng_enable,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              health_fail,
  output logic [2:0]        state
);

  localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
  localparam int BIT_W  = $clog2(WORD_W + 1);
  localparam int RUN_W  = $clog2(REP_LIMIT + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_COLLECT = 3'd2,
    S_HOLD    = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  state_t              cur_state, nxt_state;
  logic [WARM_W-1:0]   warm_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [RUN_W-1:0]    run_len;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [WORD_W-1:0]   shreg;
  logic                last_bit;
  logic                stop_pend;

  logic rep_active, rep_match, rep_trip, tmo_trip;
  logic word_done, xfer, warm_done;

  // run_len == 0 means no bit has been seen since warm-up, so the next one starts a run
  assign rep_active = (cur_state == S_COLLECT) || (cur_state == S_HOLD);
  assign rep_match  = rnd_valid && (run_len != '0) && (rnd_bit == last_bit);
  assign rep_trip   = rep_active && rep_match && (run_len >= RUN_W'(REP_LIMIT - 1));
  assign tmo_trip   = (cur_state == S_COLLECT) && !rnd_valid &&
                      (idle_cnt >= IDLE_W'(TIMEOUT - 1));
  assign word_done  = (cur_state == S_COLLECT) && rnd_valid &&
                      (bit_cnt == BIT_W'(WORD_W - 1));
  assign xfer       = (cur_state == S_HOLD) && word_ready;
  assign warm_done  = (warm_cnt == WARM_W'(WARMUP_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  // Health trips take priority over stop and over word completion
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:    if (start && !stop) nxt_state = S_WARMUP;
      S_WARMUP:  if (stop) nxt_state = S_IDLE;
                 else if (warm_done) nxt_state = S_COLLECT;
      S_COLLECT: if (rep_trip || tmo_trip) nxt_state = S_FAIL;
                 else if (stop) nxt_state = S_IDLE;
                 else if (word_done) nxt_state = S_HOLD;
      S_HOLD:    if (rep_trip) nxt_state = S_FAIL;
                 else if (xfer) nxt_state = (stop_pend || stop) ? S_IDLE : S_COLLECT;
      S_FAIL:    if (clear_fail) nxt_state = S_IDLE;
      default:   nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt    <= '0;
      bit_cnt     <= '0;
      run_len     <= '0;
      idle_cnt    <= '0;
      shreg       <= '0;
      last_bit    <= 1'b0;
      stop_pend   <= 1'b0;
      word_out    <= '0;
      trng_enable <= 1'b0;
      word_valid  <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (cur_state == S_WARMUP && !warm_done) warm_cnt <= warm_cnt + 1'b1;
      else                                     warm_cnt <= '0;

      if (cur_state == S_COLLECT && nxt_state == S_COLLECT && rnd_valid) begin
        shreg   <= {shreg[WORD_W-2:0], rnd_bit};
        bit_cnt <= bit_cnt + 1'b1;
      end else if (cur_state != S_COLLECT || nxt_state != S_COLLECT) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end

      if (word_done && nxt_state == S_HOLD) word_out <= {shreg[WORD_W-2:0], rnd_bit};

      // The run continues across HOLD even though those bits are not packed
      if (!rep_active || nxt_state == S_FAIL || nxt_state == S_IDLE) begin
        run_len  <= '0;
        last_bit <= 1'b0;
      end else if (rnd_valid) begin
        last_bit <= rnd_bit;
        if (!rep_match)                         run_len <= RUN_W'(1);
        else if (run_len != RUN_W'(REP_LIMIT)) run_len <= run_len + 1'b1;
      end

      if (cur_state == S_COLLECT && nxt_state == S_COLLECT && !rnd_valid) begin
        if (idle_cnt != IDLE_W'(TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end

      if (cur_state == S_HOLD && nxt_state == S_HOLD) begin
        if (stop) stop_pend <= 1'b1;
      end else begin
        stop_pend <= 1'b0;
      end

      trng_enable <= (nxt_state == S_WARMUP) || (nxt_state == S_COLLECT) ||
                     (nxt_state == S_HOLD);
      word_valid  <= (nxt_state == S_HOLD);
      health_fail <= (nxt_state == S_FAIL);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed self-checking bench for trng_ctrl with small parameters
// (WORD_W=8, WARMUP_CYCLES=4, REP_LIMIT=4, TIMEOUT=16).
module tb_trng_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, clear_fail, rnd_bit, rnd_valid, word_ready;
  logic       trng_enable, word_valid, health_fail;
  logic [7:0] word_out;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  trng_ctrl #(
    .WORD_W(8), .WARMUP_CYCLES(4), .REP_LIMIT(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .clear_fail(clear_fail), .rnd_bit(rnd_bit), .rnd_valid(rnd_valid),
    .word_ready(word_ready), .trng_enable(trng_enable), .word_out(word_out),
    .word_valid(word_valid), .health_fail(health_fail), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point
  task automatic applyStimulus(input logic s, input logic p, input logic c,
                               input logic b, input logic v, input logic r);
    start = s; stop = p; clear_fail = c; rnd_bit = b; rnd_valid = v; word_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic startAndWarm();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("start_state", 32'(state), 32'd1);
    checkOutput("start_enable", 32'(trng_enable), 32'd1);
    repeat (3) applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("warm_state", 32'(state), 32'd1);
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("collect_state", 32'(state), 32'd2);
  endtask

  task automatic feedBits(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, bits[7-i], 1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; stop = 0; clear_fail = 0; rnd_bit = 0; rnd_valid = 0; word_ready = 0;
    #12;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_enable", 32'(trng_enable), 32'd0);
    checkOutput("rst_valid", 32'(word_valid), 32'd0);
    checkOutput("rst_fail", 32'(health_fail), 32'd0);
    checkOutput("rst_word", 32'(word_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    startAndWarm();
    feedBits(8'b1010_1010, 7);
    checkOutput("aa_not_yet", 32'(word_valid), 32'd0);
    feedBits(8'b0000_0000, 1);
    checkOutput("aa_valid", 32'(word_valid), 32'd1);
    checkOutput("aa_word", 32'(word_out), 32'hAA);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, (i % 2 == 0) ? 1'b1 : 1'b0, 1, 0);
      checkOutput("hold_word", 32'(word_out), 32'hAA);
      checkOutput("hold_state", 32'(state), 32'd3);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("xfer_valid", 32'(word_valid), 32'd0);
    checkOutput("xfer_state", 32'(state), 32'd2);

    feedBits(8'b1100_1101, 8);
    checkOutput("cd_valid", 32'(word_valid), 32'd1);
    checkOutput("cd_word", 32'(word_out), 32'hCD);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("cd_xfer_state", 32'(state), 32'd2);

    feedBits(8'b0111_0000, 4);
    checkOutput("rep_pre_fail", 32'(health_fail), 32'd0);
    feedBits(8'b1000_0000, 1);
    checkOutput("rep_fail", 32'(health_fail), 32'd1);
    checkOutput("rep_enable", 32'(trng_enable), 32'd0);
    checkOutput("rep_state", 32'(state), 32'd4);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("fail_start_ign", 32'(state), 32'd4);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("clear_state", 32'(state), 32'd0);
    checkOutput("clear_fail", 32'(health_fail), 32'd0);

    startAndWarm();
    repeat (15) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("tmo_pre_state", 32'(state), 32'd2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("tmo_state", 32'(state), 32'd4);
    checkOutput("tmo_fail", 32'(health_fail), 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 0);

    startAndWarm();
    repeat (14) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    repeat (14) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("tmo_rst_state", 32'(state), 32'd2);
    checkOutput("tmo_rst_fail", 32'(health_fail), 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("stop_collect", 32'(state), 32'd0);

    startAndWarm();
    feedBits(8'b1010_1000, 5);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("partial_state", 32'(state), 32'd0);
    checkOutput("partial_valid", 32'(word_valid), 32'd0);
    checkOutput("partial_enable", 32'(trng_enable), 32'd0);

    startAndWarm();
    feedBits(8'b0110_0101, 8);
    checkOutput("w65_word", 32'(word_out), 32'h65);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("hold_stop_state", 32'(state), 32'd3);
    checkOutput("hold_stop_valid", 32'(word_valid), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("pend_state", 32'(state), 32'd0);
    checkOutput("pend_valid", 32'(word_valid), 32'd0);
    checkOutput("pend_enable", 32'(trng_enable), 32'd0);

    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("startstop_state", 32'(state), 32'd0);
    checkOutput("startstop_en", 32'(trng_enable), 32'd0);

    startAndWarm();
    feedBits(8'b1001_1001, 8);
    checkOutput("w99_word", 32'(word_out), 32'h99);
    checkOutput("w99_valid", 32'(word_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(word_valid), 32'd0);
    checkOutput("arst_enable", 32'(trng_enable), 32'd0);
    checkOutput("arst_fail", 32'(health_fail), 32'd0);
    checkOutput("arst_state", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
